dmem_lsu: RTL

Load/store unit answering the data-memory control signals the decode stage emits (D_MEM_read, D_MEM_write, D_MEM_mode) in the MEM stage of the RV32I pipeline. It does three jobs:
- Converts byte, halfword and word accesses into word-aligned requests on a valid/ready data-memory bus with byte enables.
- Sign- or zero-extends load data.
- Stalls the pipeline until the bus responds, and flags misaligned accesses and bus timeouts.

---
 rtl/dmem_lsu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit. Turns byte/halfword/word accesses into
// word-aligned valid/ready bus requests with byte enables, extends load data,
// stalls the pipeline until the bus answers, and flags misalignment/timeouts.

`ifndef MEMORY_MODE_WIDTH
`define MEMORY_MODE_WIDTH 2
`endif
`ifndef BYTE_MEMORY_MODE
`define BYTE_MEMORY_MODE 2'b00
`endif
`ifndef HALFWORD_MEMORY_MODE
`define HALFWORD_MEMORY_MODE 2'b01
`endif
`ifndef WORD_MEMORY_MODE
`define WORD_MEMORY_MODE 2'b10
`endif

module dmem_lsu #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          D_MEM_read,
  input  logic                          D_MEM_write,
  input  logic [`MEMORY_MODE_WIDTH-1:0] D_MEM_mode,
  input  logic                          load_unsigned,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [31:0]                   wdata,
  output logic                          stall,
  output logic [31:0]                   rdata,
  output logic                          misaligned,
  output logic                          access_fault,
  output logic                          bus_req_valid,
  input  logic                          bus_req_ready,
  output logic                          bus_we,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [3:0]                    bus_be,
  output logic [31:0]                   bus_wdata,
  input  logic                          bus_rsp_valid,
  input  logic [31:0]                   bus_rsp_data,
  input  logic                          bus_rsp_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [`MEMORY_MODE_WIDTH-1:0]   mode_q;
  logic                            uns_q;
  logic                            we_q;
  logic [3:0]                      be_q;
  logic [31:0]                     wdata_q;
  logic [31:0]                     rdata_q, rdata_d;
  logic [31:0]                     cnt_q, cnt_d;

  logic                            req;
  logic                            mis;
  logic [3:0]                      be_new;
  logic [31:0]                     wdata_new;
  logic [31:0]                     load_ext;
  logic                            timeout_hit;
  logic                            latch_en;
  logic                            stall_c;
  logic                            mis_c;
  logic                            fault_c;
  logic                            valid_c;

  assign req = D_MEM_read | D_MEM_write;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES);

  // Misalignment check, byte enables and lane-replicated store data for the incoming access
  always_comb begin
    mis       = 1'b0;
    be_new    = 4'b1111;
    wdata_new = '0;
    case (D_MEM_mode)
      `BYTE_MEMORY_MODE: begin
        be_new = 4'b0001 << addr[1:0];
        if (D_MEM_write) wdata_new = {4{wdata[7:0]}};
      end
      `HALFWORD_MEMORY_MODE: begin
        mis    = addr[0];
        be_new = 4'b0011 << addr[1:0];
        if (D_MEM_write) wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        mis    = (addr[1:0] != 2'b00);
        be_new = 4'b1111;
        if (D_MEM_write) wdata_new = wdata;
      end
    endcase
  end

  // Lane selection and sign/zero extension of the returned read word
  always_comb begin
    load_ext = bus_rsp_data;
    case (mode_q)
      `BYTE_MEMORY_MODE: begin
        load_ext = {{24{~uns_q & bus_rsp_data[8*addr_q[1:0] + 7]}},
                    bus_rsp_data[8*addr_q[1:0] +: 8]};
      end
      `HALFWORD_MEMORY_MODE: begin
        if (addr_q[1])
          load_ext = {{16{~uns_q & bus_rsp_data[31]}}, bus_rsp_data[31:16]};
        else
          load_ext = {{16{~uns_q & bus_rsp_data[15]}}, bus_rsp_data[15:0]};
      end
      default: load_ext = bus_rsp_data;
    endcase
  end

  // Next-state, handshake and pulse outputs of the access FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    latch_en = 1'b0;
    stall_c  = 1'b0;
    mis_c    = 1'b0;
    fault_c  = 1'b0;
    valid_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (mis) begin
            mis_c = 1'b1;
          end else begin
            stall_c  = 1'b1;
            latch_en = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        valid_c = 1'b1;
        if (bus_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        stall_c = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
        if (bus_rsp_valid) begin
          if (bus_rsp_err) fault_c = 1'b1;
          else if (!we_q)  rdata_d = load_ext;
          state_d = DONE;
        end else if (timeout_hit) begin
          fault_c = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        // Inputs seen here belong to the instruction that just completed
        state_d = IDLE;
      end
    endcase
  end

  // State, timeout counter, load result and latched request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (latch_en) begin
        addr_q  <= addr;
        mode_q  <= D_MEM_mode;
        uns_q   <= load_unsigned;
        we_q    <= D_MEM_write;
        be_q    <= be_new;
        wdata_q <= wdata_new;
      end
    end
  end

  // Bus fields are only presented while the request is held, so they read 0 otherwise
  always_comb begin
    bus_req_valid = valid_c;
    bus_we        = 1'b0;
    bus_addr      = '0;
    bus_be        = '0;
    bus_wdata     = '0;
    if (state_q == REQ) begin
      bus_we    = we_q;
      bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      bus_be    = be_q;
      bus_wdata = wdata_q;
    end
  end

  assign stall        = stall_c & ~rst;
  assign misaligned   = mis_c & ~rst;
  assign access_fault = fault_c & ~rst;
  assign rdata        = rdata_q;

endmodule
